rank_pifo: RTL

RANK_PIFO -- requirements
Module: rank_pifo

---
 rtl/rank_pipe_pkg.sv | 17 +
 rtl/pifo_cell.sv | 83 ++++++++
 rtl/rank_pifo.sv | 137 +++++++++++++
 3 files changed

// File: rtl/rank_pipe_pkg.sv
// Shared definitions for the rank pipeline blocks: default field widths and the
// slot entry record.
package rank_pipe_pkg;

  localparam int unsigned RankWidthDef = 16;
  localparam int unsigned MetaWidthDef = 16;

  // Bit order {valid, rank, meta} is the layout every rank block uses for a slot.
  typedef struct packed {
    logic                    valid;
    logic [RankWidthDef-1:0] rank;
    logic [MetaWidthDef-1:0] meta;
  } rank_entry_t;

  localparam int unsigned EntryWidthDef = $bits(rank_entry_t);

endpackage

// File: rtl/pifo_cell.sv
// One sorted slot: holds, takes the incoming entry, or shifts from a neighbour,
// based on its own rank compare and the compare results of its neighbours.
module pifo_cell
  import rank_pipe_pkg::*;
#(
  parameter int unsigned RANK_WIDTH = RankWidthDef,
  parameter int unsigned META_WIDTH = MetaWidthDef,
  parameter bit          IS_HEAD    = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ins_i,
  input  logic                  deq_i,
  input  logic [RANK_WIDTH-1:0] new_rank_i,
  input  logic [META_WIDTH-1:0] new_meta_i,
  input  logic                  left_valid_i,
  input  logic [RANK_WIDTH-1:0] left_rank_i,
  input  logic [META_WIDTH-1:0] left_meta_i,
  input  logic                  left_before_i,
  input  logic                  right_valid_i,
  input  logic [RANK_WIDTH-1:0] right_rank_i,
  input  logic [META_WIDTH-1:0] right_meta_i,
  input  logic                  right_before_i,
  output logic                  valid_o,
  output logic [RANK_WIDTH-1:0] rank_o,
  output logic [META_WIDTH-1:0] meta_o,
  output logic                  before_o
);

  localparam logic [1:0] SelHold  = 2'd0;
  localparam logic [1:0] SelNew   = 2'd1;
  localparam logic [1:0] SelLeft  = 2'd2;
  localparam logic [1:0] SelRight = 2'd3;

  logic                  valid_q;
  logic [RANK_WIDTH-1:0] rank_q;
  logic [META_WIDTH-1:0] meta_q;
  logic [1:0]            sel;

  // The new entry belongs at or ahead of this slot (ties stay behind).
  assign before_o = !valid_q || (rank_q > new_rank_i);

  always_comb begin
    sel = SelHold;
    if (ins_i && !deq_i) begin
      if (left_before_i)  sel = SelLeft;
      else if (before_o)  sel = SelNew;
    end else if (!ins_i && deq_i) begin
      sel = SelRight;
    end else if (ins_i && deq_i) begin
      // Sorting among the survivors: slot i now plays the role of old slot i+1.
      if (!right_before_i)             sel = SelRight;
      else if (IS_HEAD || !before_o)   sel = SelNew;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
    end else begin
      unique case (sel)
        SelNew:   valid_q <= 1'b1;
        SelLeft:  valid_q <= left_valid_i;
        SelRight: valid_q <= right_valid_i;
        default:  valid_q <= valid_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    unique case (sel)
      SelNew:   begin rank_q <= new_rank_i;   meta_q <= new_meta_i;   end
      SelLeft:  begin rank_q <= left_rank_i;  meta_q <= left_meta_i;  end
      SelRight: begin rank_q <= right_rank_i; meta_q <= right_meta_i; end
      default:  begin rank_q <= rank_q;       meta_q <= meta_q;       end
    endcase
  end

  assign valid_o = valid_q;
  assign rank_o  = rank_q;
  assign meta_o  = meta_q;

endmodule

// File: rtl/rank_pifo.sv
// Push-in first-out priority queue: DEPTH slots kept sorted by ascending rank,
// filled from a fall-through rank FIFO and drained from the lowest rank.
module rank_pifo
  import rank_pipe_pkg::*;
#(
  parameter int unsigned RANK_WIDTH = RankWidthDef,
  parameter int unsigned META_WIDTH = MetaWidthDef,
  parameter int unsigned DEPTH      = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         src_valid,
  input  logic [RANK_WIDTH-1:0]        src_rank,
  input  logic [META_WIDTH-1:0]        src_meta,
  output logic                         src_remove,
  input  logic                         deq_req,
  output logic                         deq_valid,
  output logic [RANK_WIDTH-1:0]        deq_rank,
  output logic [META_WIDTH-1:0]        deq_meta,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         full,
  output logic                         err_underflow
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic                  slot_valid  [DEPTH];
  logic [RANK_WIDTH-1:0] slot_rank   [DEPTH];
  logic [META_WIDTH-1:0] slot_meta   [DEPTH];
  logic                  slot_before [DEPTH];

  logic                  l_valid  [DEPTH];
  logic [RANK_WIDTH-1:0] l_rank   [DEPTH];
  logic [META_WIDTH-1:0] l_meta   [DEPTH];
  logic                  l_before [DEPTH];
  logic                  r_valid  [DEPTH];
  logic [RANK_WIDTH-1:0] r_rank   [DEPTH];
  logic [META_WIDTH-1:0] r_meta   [DEPTH];
  logic                  r_before [DEPTH];

  logic [CW-1:0]         count_q, count_d;
  logic                  deq_valid_q;
  logic [RANK_WIDTH-1:0] deq_rank_q;
  logic [META_WIDTH-1:0] deq_meta_q;
  logic                  err_q;
  logic                  deq_acc, ins_acc;

  assign empty      = (count_q == '0);
  assign full       = (count_q == CW'(DEPTH));
  assign deq_acc    = deq_req && !empty;
  assign ins_acc    = !rst && src_valid && (!full || deq_acc);
  assign src_remove = ins_acc;

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    if (i == 0) begin : g_head
      assign l_valid[i]  = 1'b0;
      assign l_rank[i]   = '0;
      assign l_meta[i]   = '0;
      assign l_before[i] = 1'b0;
    end else begin : g_mid
      assign l_valid[i]  = slot_valid[i-1];
      assign l_rank[i]   = slot_rank[i-1];
      assign l_meta[i]   = slot_meta[i-1];
      assign l_before[i] = slot_before[i-1];
    end

    // Beyond the tail sits an always-empty slot.
    if (i == DEPTH - 1) begin : g_tail
      assign r_valid[i]  = 1'b0;
      assign r_rank[i]   = '0;
      assign r_meta[i]   = '0;
      assign r_before[i] = 1'b1;
    end else begin : g_body
      assign r_valid[i]  = slot_valid[i+1];
      assign r_rank[i]   = slot_rank[i+1];
      assign r_meta[i]   = slot_meta[i+1];
      assign r_before[i] = slot_before[i+1];
    end

    pifo_cell #(
      .RANK_WIDTH (RANK_WIDTH),
      .META_WIDTH (META_WIDTH),
      .IS_HEAD    (i == 0)
    ) u_cell (
      .clk            (clk),
      .rst            (rst),
      .ins_i          (ins_acc),
      .deq_i          (deq_acc),
      .new_rank_i     (src_rank),
      .new_meta_i     (src_meta),
      .left_valid_i   (l_valid[i]),
      .left_rank_i    (l_rank[i]),
      .left_meta_i    (l_meta[i]),
      .left_before_i  (l_before[i]),
      .right_valid_i  (r_valid[i]),
      .right_rank_i   (r_rank[i]),
      .right_meta_i   (r_meta[i]),
      .right_before_i (r_before[i]),
      .valid_o        (slot_valid[i]),
      .rank_o         (slot_rank[i]),
      .meta_o         (slot_meta[i]),
      .before_o       (slot_before[i])
    );
  end

  always_comb begin
    count_d = count_q;
    if (ins_acc && !deq_acc)      count_d = count_q + CW'(1);
    else if (!ins_acc && deq_acc) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q     <= '0;
      deq_valid_q <= 1'b0;
      deq_rank_q  <= '0;
      deq_meta_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      count_q     <= count_d;
      deq_valid_q <= deq_acc;
      if (deq_acc) begin
        deq_rank_q <= slot_rank[0];
        deq_meta_q <= slot_meta[0];
      end
      if (deq_req && empty) err_q <= 1'b1;
    end
  end

  assign count         = count_q;
  assign deq_valid     = deq_valid_q;
  assign deq_rank      = deq_rank_q;
  assign deq_meta      = deq_meta_q;
  assign err_underflow = err_q;

endmodule
